// File: rtl/aes_core_ctrl_if.sv
// Register bus between a host and aes_core_ctrl: independent write and read request/ack channels.
interface aes_core_ctrl_if;
    logic        wr_valid;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic        rd_valid;
    logic [31:0] rd_addr;
    logic        rd_ack;
    logic [31:0] rd_data;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
        input  wr_ack, rd_ack, rd_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
        output wr_ack, rd_ack, rd_data
    );
endinterface

// File: rtl/aes_core_ctrl.sv
// Register-mapped controller for a fixed-latency aes_256 core: key/plaintext staging, run sequencing,
// ciphertext capture and status. Completion irq is generated only when AES_CORE_CTRL_IRQ_EN is defined.
module aes_core_ctrl #(
    parameter int unsigned AES_LATENCY = 29,
    parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
    input  logic           clk_main_a0,
    input  logic           rst_main,
    aes_core_ctrl_if.slave bus,
    output logic [255:0]   aes_key,
    output logic [127:0]   aes_state,
    input  logic [127:0]   aes_out,
    output logic           busy,
    output logic           irq
);
    localparam int unsigned      CNT_W    = (AES_LATENCY > 2) ? $clog2(AES_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(AES_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, RUN, CAPTURE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [255:0]     key_q;
    logic [127:0]     pt_q, ct_q;
    logic [31:0]      run_cnt_q;
    logic             done_q, err_q;
    logic             wr_ack_q, rd_ack_q;
    logic [31:0]      rd_data_q, rd_mux;
    logic             wr_acc, rd_acc, ctrl_wr, start_req, key_sel, pt_sel, discard;

    assign wr_acc    = bus.wr_valid & ~wr_ack_q;
    assign rd_acc    = bus.rd_valid & ~rd_ack_q;
    assign ctrl_wr   = wr_acc && (bus.wr_addr == 32'h0);
    assign start_req = ctrl_wr & bus.wr_data[0];
    assign key_sel   = (bus.wr_addr >= 32'h10) && (bus.wr_addr <= 32'h2C) && (bus.wr_addr[1:0] == 2'b00);
    assign pt_sel    = (bus.wr_addr >= 32'h30) && (bus.wr_addr <= 32'h3C) && (bus.wr_addr[1:0] == 2'b00);
    assign busy      = (state_q != IDLE);
    // Anything that could disturb the core inputs or restart a run is refused while busy.
    assign discard   = busy & (start_req | (wr_acc & (key_sel | pt_sel)));

    always_ff @(posedge clk_main_a0) begin
        if (rst_main) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_req) state_d = RUN;
            RUN:     if (cnt_q == '0) state_d = CAPTURE;
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_mux = ERR_RDATA;
        if (bus.rd_addr == 32'h00) rd_mux = '0;
        if (bus.rd_addr == 32'h04) rd_mux = {29'd0, err_q, done_q, busy};
        if (bus.rd_addr == 32'h50) rd_mux = run_cnt_q;
        for (int unsigned i = 0; i < 8; i++)
            if (bus.rd_addr == 32'h10 + 4 * i) rd_mux = key_q[32*i +: 32];
        for (int unsigned i = 0; i < 4; i++) begin
            if (bus.rd_addr == 32'h30 + 4 * i) rd_mux = pt_q[32*i +: 32];
            if (bus.rd_addr == 32'h40 + 4 * i) rd_mux = ct_q[32*i +: 32];
        end
    end

    always_ff @(posedge clk_main_a0) begin
        if (rst_main) begin
            cnt_q     <= '0;
            key_q     <= '0;
            pt_q      <= '0;
            ct_q      <= '0;
            run_cnt_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            wr_ack_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            wr_ack_q  <= wr_acc;
            rd_ack_q  <= rd_acc;
            rd_data_q <= rd_acc ? rd_mux : '0;

            if (state_q == IDLE && start_req) cnt_q <= CNT_LOAD;
            else if (state_q == RUN)          cnt_q <= cnt_q - CNT_W'(1);

            if (wr_acc && !busy) begin
                for (int unsigned i = 0; i < 8; i++)
                    if (bus.wr_addr == 32'h10 + 4 * i) key_q[32*i +: 32] <= bus.wr_data;
                for (int unsigned i = 0; i < 4; i++)
                    if (bus.wr_addr == 32'h30 + 4 * i) pt_q[32*i +: 32] <= bus.wr_data;
            end

            // Capture wins over a CLR_DONE landing in the same cycle.
            if (state_q == CAPTURE) begin
                ct_q      <= aes_out;
                run_cnt_q <= run_cnt_q + 32'd1;
                done_q    <= 1'b1;
            end else if (ctrl_wr && bus.wr_data[1]) begin
                done_q <= 1'b0;
            end

            if (discard)                      err_q <= 1'b1;
            else if (ctrl_wr && bus.wr_data[2]) err_q <= 1'b0;
        end
    end

    assign aes_key     = key_q;
    assign aes_state   = pt_q;
    assign bus.wr_ack  = wr_ack_q;
    assign bus.rd_ack  = rd_ack_q;
    assign bus.rd_data = rd_data_q;

`ifdef AES_CORE_CTRL_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk_main_a0) begin
        if (rst_main) irq_q <= 1'b0;
        else          irq_q <= (state_q == CAPTURE);
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif
endmodule
